// File: rtl/exp_max_tree_pipe_pkg.sv
// Shared definitions for the max-exponent tree: sizing helper and candidate record layout.
// A candidate is packed as {v, exp, idx}, with idx in the least significant bits.
package exp_pkg;

  localparam int DEF_EXP_WIDTH = 5;
  localparam int DEF_LANES     = 8;

  localparam int CAND_V_W = 1;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cand_w(input int exp_w, input int idx_w);
    return CAND_V_W + exp_w + idx_w;
  endfunction

endpackage

// File: rtl/exp_max_tree_pipe_if.sv
// Beat-level bus of the max-exponent tree.
// Handshake: a beat moves on a channel in every cycle where valid && ready are both high;
// the source holds valid and data stable until then, and ready may depend on the sink's state only.
interface exp_max_tree_pipe_if import exp_pkg::*; #(
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int IDX_WIDTH = clog2_f(LANES)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [EXP_WIDTH*LANES-1:0] in_exp;
  logic [LANES-1:0]           in_mask;
  logic                       out_valid;
  logic                       out_ready;
  logic [EXP_WIDTH-1:0]       out_max;
  logic [IDX_WIDTH-1:0]       out_idx;
  logic [EXP_WIDTH*LANES-1:0] out_shift;
  logic                       out_none;

  modport master (
    output in_valid, in_exp, in_mask, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_shift, out_none
  );

  modport slave (
    input  in_valid, in_exp, in_mask, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_shift, out_none
  );
endinterface

// File: rtl/exp_max_tree_pipe_pair_cell.sv
// One node of the compare tree: picks the larger valid candidate, ties to the lower index (a).
module exp_max_pair_cell import exp_pkg::*; #(
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int IDX_WIDTH = 3,
  localparam int CW       = cand_w(EXP_WIDTH, IDX_WIDTH)
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [CW-1:0] y
);
  logic                 a_v;
  logic                 b_v;
  logic [EXP_WIDTH-1:0] a_e;
  logic [EXP_WIDTH-1:0] b_e;

  assign a_v = a[CW-1];
  assign b_v = b[CW-1];
  assign a_e = a[IDX_WIDTH +: EXP_WIDTH];
  assign b_e = b[IDX_WIDTH +: EXP_WIDTH];

  always_comb begin
    y = a;
    if (!a_v)           y = b;
    else if (!b_v)      y = a;
    else if (b_e > a_e) y = b;
  end
endmodule

// File: rtl/exp_max_tree_pipe.sv
// Pipelined masked max-exponent finder: log2(LANES) registered compare levels, then a
// registered shift stage producing max, winning lane and per-lane alignment shifts.
module exp_max_tree_pipe import exp_pkg::*; #(
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int IDX_WIDTH = clog2_f(LANES)
) (
  input logic                clk,
  input logic                rst,
  exp_max_tree_pipe_if.slave bus
);
  localparam int S  = clog2_f(LANES);
  localparam int CW = cand_w(EXP_WIDTH, IDX_WIDTH);

  // Single stall domain: the whole pipe moves only when the output slot is free or draining.
  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int N_IN  = LANES >> k;
    localparam int N_OUT = LANES >> (k + 1);

    logic [N_IN-1:0][CW-1:0]    c_in;
    logic [N_OUT-1:0][CW-1:0]   c_nx;
    logic [N_OUT-1:0][CW-1:0]   c_q;
    logic                       v_in;
    logic [EXP_WIDTH*LANES-1:0] e_in;
    logic [LANES-1:0]           m_in;
    logic                       v_q;
    logic [EXP_WIDTH*LANES-1:0] e_q;
    logic [LANES-1:0]           m_q;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign c_in[i] = {bus.in_mask[i], bus.in_exp[i*EXP_WIDTH +: EXP_WIDTH], IDX_WIDTH'(i)};
      end
      assign v_in = bus.in_valid;
      assign e_in = bus.in_exp;
      assign m_in = bus.in_mask;
    end else begin : g_chain
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign e_in = g_stage[k-1].e_q;
      assign m_in = g_stage[k-1].m_q;
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      exp_max_pair_cell #(
        .EXP_WIDTH (EXP_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
      ) u_cell (
        .a (c_in[2*j]),
        .b (c_in[2*j+1]),
        .y (c_nx[j])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= '0;
        e_q <= '0;
        m_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= c_nx;
        e_q <= e_in;
        m_q <= m_in;
      end
    end
  end

  logic [CW-1:0]              root;
  logic                       root_v;
  logic [EXP_WIDTH-1:0]       root_e;
  logic [IDX_WIDTH-1:0]       root_i;
  logic [EXP_WIDTH*LANES-1:0] last_e;
  logic [LANES-1:0]           last_m;
  logic                       last_v;

  assign root   = g_stage[S-1].c_q[0];
  assign root_v = root[CW-1];
  assign root_e = root[IDX_WIDTH +: EXP_WIDTH];
  assign root_i = root[IDX_WIDTH-1:0];
  assign last_e = g_stage[S-1].e_q;
  assign last_m = g_stage[S-1].m_q;
  assign last_v = g_stage[S-1].v_q;

  logic [EXP_WIDTH-1:0]       max_nx;
  logic [IDX_WIDTH-1:0]       idx_nx;
  logic [EXP_WIDTH*LANES-1:0] shift_nx;

  // An empty beat reports zeros everywhere so downstream never sees stale lane data.
  always_comb begin
    max_nx   = root_v ? root_e : '0;
    idx_nx   = root_v ? root_i : '0;
    shift_nx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (root_v && last_m[i]) begin
        shift_nx[i*EXP_WIDTH +: EXP_WIDTH] = max_nx - last_e[i*EXP_WIDTH +: EXP_WIDTH];
      end
    end
  end

  logic                       out_valid_q;
  logic [EXP_WIDTH-1:0]       out_max_q;
  logic [IDX_WIDTH-1:0]       out_idx_q;
  logic [EXP_WIDTH*LANES-1:0] out_shift_q;
  logic                       out_none_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_shift_q <= '0;
      out_none_q  <= 1'b0;
    end else if (en) begin
      out_valid_q <= last_v;
      out_max_q   <= max_nx;
      out_idx_q   <= idx_nx;
      out_shift_q <= shift_nx;
      out_none_q  <= !root_v;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_none  = out_none_q;
endmodule

// File: tb/tb_exp_max_tree_pipe.sv
// Scoreboard bench for exp_max_tree_pipe with LANES=8, EXP_WIDTH=5.
module tb_exp_max_tree_pipe;
  localparam int EW = 5;
  localparam int LN = 8;
  localparam int IW = 3;
  localparam int RW = 1 + EW + IW + EW*LN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exp_max_tree_pipe_if #(.EXP_WIDTH(EW), .LANES(LN)) bus ();

  exp_max_tree_pipe #(.EXP_WIDTH(EW), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int            vec_cnt = 0;
  int            err_cnt = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur_exp = '0;
  int            ready_mode = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model and helpers ----------------
  function automatic logic [RW-1:0] model(input logic [EW*LN-1:0] e, input logic [LN-1:0] m);
    int            best;
    logic [EW-1:0] bm;
    logic [EW*LN-1:0] sh;
    best = -1;
    bm   = '0;
    sh   = '0;
    for (int i = 0; i < LN; i++) begin
      if (m[i] && (best < 0 || e[i*EW +: EW] > bm)) begin
        best = i;
        bm   = e[i*EW +: EW];
      end
    end
    if (best < 0) return {1'b1, {(RW-1){1'b0}}};
    for (int i = 0; i < LN; i++) begin
      if (m[i]) sh[i*EW +: EW] = bm - e[i*EW +: EW];
    end
    return {1'b0, bm, IW'(best), sh};
  endfunction

  function automatic logic [EW*LN-1:0] lv(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
    return {EW'(a7), EW'(a6), EW'(a5), EW'(a4), EW'(a3), EW'(a2), EW'(a1), EW'(a0)};
  endfunction

  function automatic logic [RW-1:0] res(input bit none, input int mx, input int ix,
                                        input logic [EW*LN-1:0] sh);
    return {none, EW'(mx), IW'(ix), sh};
  endfunction

  // ---------------- monitor: compare head of queue, push on accept ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(bus.out_valid), 64'(0));
        end else begin
          check("result", 64'({bus.out_none, bus.out_max, bus.out_idx, bus.out_shift}),
                64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    int bp_idx;
    bp_idx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          bus.out_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
          bp_idx++;
        end
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [EW*LN-1:0] e, input logic [LN-1:0] m,
                           input logic [RW-1:0] exp);
    bit acc;
    acc = 1'b0;
    bus.in_exp   = e;
    bus.in_mask  = m;
    cur_exp      = exp;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic rand_beat(input bit rand_mask);
    logic [EW*LN-1:0] e;
    logic [LN-1:0]    m;
    for (int i = 0; i < LN; i++) e[i*EW +: EW] = EW'($urandom_range(0, 31));
    m = rand_mask ? LN'($urandom_range(0, 255)) : '1;
    send_beat(e, m, model(e, m));
  endtask

  task automatic check_latency(input string tag);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(tag, 64'(lat), 64'(4));
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_exp   = '0;
    bus.in_mask  = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_max",   64'(bus.out_max),   64'(0));
    check("rst_out_idx",   64'(bus.out_idx),   64'(0));
    check("rst_out_shift", 64'(bus.out_shift), 64'(0));
    check("rst_out_none",  64'(bus.out_none),  64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill: tie on 17 resolves to lane 3
    send_beat(lv(3, 9, 2, 17, 5, 17, 0, 1), 8'hFF,
              res(0, 17, 3, lv(14, 8, 15, 0, 12, 0, 17, 16)));
    check_latency("fill_latency");
    drain();

    // Masking, all-masked and boundary values, back to back
    send_beat(lv(3, 9, 2, 17, 5, 17, 0, 1), 8'hF7,
              res(0, 17, 5, lv(14, 8, 15, 0, 12, 0, 17, 16)));
    send_beat(lv(31, 7, 22, 3, 31, 0, 9, 30), 8'h00, res(1, 0, 0, '0));
    send_beat(lv(31, 31, 31, 31, 31, 31, 31, 31), 8'hFF, res(0, 31, 0, '0));
    send_beat(lv(0, 0, 0, 0, 0, 31, 0, 0), 8'hFF,
              res(0, 31, 5, lv(31, 31, 31, 31, 31, 0, 31, 31)));
    send_beat(lv(4, 31, 6, 2, 0, 0, 0, 0), 8'hFD,
              res(0, 6, 2, lv(2, 0, 0, 4, 6, 6, 6, 6)));
    send_beat(lv(0, 0, 0, 0, 0, 0, 0, 9), 8'h80,
              res(0, 9, 7, lv(0, 0, 0, 0, 0, 0, 0, 0)));
    drain();

    // Backpressure: out_ready 1,0,0,1,...
    ready_mode = 1;
    for (int n = 0; n < 10; n++) rand_beat(1'b0);
    drain();

    // Random masks with random downstream readiness
    ready_mode = 2;
    for (int n = 0; n < 30; n++) rand_beat(1'b1);
    drain();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Reset with one result showing and three beats in flight
    for (int n = 0; n < 4; n++) rand_beat(1'b1);
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 64'(bus.out_valid), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_after_rst", 64'(bus.out_valid), 64'(0));
    rand_beat(1'b0);
    check_latency("post_rst_latency");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/exp_max_tree_pipe.md
Name: exp_max_tree_pipe

Overview:
- Pipelined, parametrised maximum-exponent finder for block-floating-point alignment in the GEMM/FFT datapath.
- Takes LANES unsigned exponents per beat, plus a lane mask, and returns three results:
  - the maximum exponent;
  - the index of the lane that wins;
  - the per-lane right-shift amount (max − exp_i) that feeds the mantissa aligners.
- Replaces the fixed 4-input combinational compare tree with a registered, valid/ready, masked N-lane tree.

Parameters:
- EXP_WIDTH, 5, exponent width in bits (≥2).
- LANES, 8, number of input exponents; power of two, 2..64.
- IDX_WIDTH, $clog2(LANES), width of the winning-lane index (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_exp  in  EXP_WIDTH*LANES  lane i occupies bits [EXP_WIDTH*(i+1)-1 : EXP_WIDTH*i].
- in_mask  in  LANES  1 = lane participates; 0 = lane ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_max  out  EXP_WIDTH  maximum exponent over unmasked lanes.
- out_idx  out  IDX_WIDTH  lowest index achieving out_max.
- out_shift  out  EXP_WIDTH*LANES  per-lane out_max − exp_i, using the same lane packing as in_exp.
- out_none  out  1  all lanes were masked in this beat.

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits are 0; out_valid=0, out_max=0, out_idx=0, out_shift=0, out_none=0. Data registers also clear to 0.
- Pipeline structure: S = log2(LANES) compare stages, followed by 1 shift stage.
  - Latency from accepted beat to out_valid is S+1 cycles (LANES=8 → 4 cycles).
  - Throughput is 1 beat/cycle when out_ready=1.
- Global stall rule: en = !out_valid || out_ready, and in_ready = en (combinational).
  - When en=0, every stage holds its contents.
  - When en=1, all stages advance together, and bubbles advance as valid=0 stages.
  - A beat is accepted iff in_valid && in_ready.
  - The output holds stable while out_valid && !out_ready.
- Compare stage k (0..S-1) reduces LANES/2^k candidates to LANES/2^(k+1). Each candidate is {valid_lane, exp, idx}.
- Pair rule, with a as the lower-index candidate and b as the higher-index candidate:
  - if !a.v → b;
  - else if !b.v → a;
  - else if b.exp > a.exp (unsigned) → b;
  - else → a.
  - Ties therefore go to the lower index.
- Stage 0 inputs: idx = lane number, v = in_mask[i].
- Raw in_exp and in_mask are carried alongside the tree through all stages so the shift stage can use them.
- Shift stage outputs:
  - out_shift_i = max − exp_i for unmasked lanes, and 0 for masked lanes. No underflow is possible because max ≥ exp_i.
  - out_none = !root.v.
  - When out_none=1: out_max=0, out_idx=0, all shifts 0.
- A masked lane's exponent value never influences any output.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted after release until a new beat is accepted.
- A beat accepted on the same cycle the output is consumed is legal, and the pipeline advances normally.

Decomposition:
- Shared package exp_pkg holds:
  - the function clog2_f;
  - a localparam for the default EXP_WIDTH;
  - the candidate record layout as packed-field width constants (CAND_W = 1+EXP_WIDTH+IDX_WIDTH).
- One sub-module: exp_max_pair_cell.
  - Combinational pair rule over two candidates with parameters EXP_WIDTH and IDX_WIDTH.
  - Instantiated LANES−1 times via generate.
  - Registers stay in the top level.

Test Plan:
- Fill: LANES=8, EXP_WIDTH=5, in_exp lanes0..7 = {3,9,2,17,5,17,0,1}, mask=FF, out_ready=1.
  - Required after 4 cycles: out_max=17, out_idx=3 (tie → lower index), out_shift = {14,8,15,0,12,0,17,16}.
- Masking: same exponents, mask=0xF7 (lane 3 off).
  - Required: out_max=17, out_idx=5, out_shift[3]=0, out_shift[0]=14.
- All masked: mask=0x00 with arbitrary exponents.
  - Required: out_none=1, out_max=0, out_idx=0, all shifts 0.
- Backpressure: stream 10 back-to-back beats with out_ready toggling 1,0,0,1,…
  - Required: in_ready=0 exactly when out_valid && !out_ready, no beat lost or duplicated, results in order, and output stable during stall.
- Boundary values: all lanes 31 → max 31, idx 0, shifts 0; one lane 31 and the rest 0 → that lane's shift 0, others 31.
- Reset mid-stream: assert rst asynchronously while 3 beats are in flight.
  - Required: out_valid drops to 0 immediately.
  - Required: after release, first out_valid comes exactly 4 cycles after the next accepted beat.
